// File: rtl/reg_file_sb.sv
// Writeback-side register file with write-before-read bypass and a per-register
// pending-write scoreboard that raises a RAW-hazard stall toward ID.

module sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturate at both ends; the attempted step past a limit is the error event.
  assign err = (inc && !dec && cnt == CNT_MAX) || (dec && !inc && cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  cnt <= '0;
    else if (inc && !dec && cnt != CNT_MAX)   cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)        cnt <= cnt - 1'b1;
  end
endmodule

module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic              hazard_stall,
  output logic              sb_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0][CNT_W-1:0]  pend;
  logic [NUM_REGS-1:0]             err_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   regs <= '0;
    else if (wb_reg_write && wb_write_reg != '0) regs[wb_write_reg] <= wb_data;
  end

  assign pend[0]    = '0;
  assign err_vec[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_sb
      sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (iss_valid && iss_dest == ADDR_W'(r)),
        .dec (wb_reg_write && wb_write_reg == ADDR_W'(r)),
        .cnt (pend[r]),
        .err (err_vec[r])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sb_err <= 1'b0;
    else if (|err_vec) sb_err <= 1'b1;
  end

  logic wb_hit_rs, wb_hit_rt, hz_rs, hz_rt;
  assign wb_hit_rs = wb_reg_write && wb_write_reg == id_rs && id_rs != '0;
  assign wb_hit_rt = wb_reg_write && wb_write_reg == id_rt && id_rt != '0;

  // A lone in-flight write landing this cycle is forwarded, so it does not stall.
  assign hz_rs = id_rs != '0 && pend[id_rs] != '0 &&
                 !(pend[id_rs] == CNT_W'(1) && wb_hit_rs);
  assign hz_rt = id_rt != '0 && pend[id_rt] != '0 &&
                 !(pend[id_rt] == CNT_W'(1) && wb_hit_rt);

  assign hazard_stall = !rst && (hz_rs || hz_rt);
  assign id_rs_data   = rst ? '0 : (wb_hit_rs ? wb_data : regs[id_rs]);
  assign id_rt_data   = rst ? '0 : (wb_hit_rt ? wb_data : regs[id_rt]);
  assign dbg_data     = rst ? '0 : regs[dbg_addr];
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized + directed bench for reg_file_sb; a queue-based scoreboard checks
// every cycle's combinational outputs against an array-level reference model.

module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_data;
  logic [4:0]  id_rs, id_rt, iss_dest, dbg_addr;
  logic [31:0] id_rs_data, id_rt_data, dbg_data;
  logic        iss_valid, hazard_stall, sb_err;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_data(wb_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .hazard_stall(hazard_stall),
    .sb_err(sb_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] dbg_d;
    logic        stall;
    logic        err;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: plain arrays and integer counters.
  logic [31:0] m_regs[32];
  int          m_pend[32];
  bit          m_err;

  function automatic void m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a != 0 && wb_reg_write && int'(wb_write_reg) == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_hz(input int a);
    if (a == 0 || m_pend[a] == 0) return 1'b0;
    if (m_pend[a] == 1 && wb_reg_write && int'(wb_write_reg) == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_clock();
    for (int r = 1; r < 32; r++) begin
      bit i, d;
      i = iss_valid && int'(iss_dest) == r;
      d = wb_reg_write && int'(wb_write_reg) == r;
      if (i && !d) begin
        if (m_pend[r] == 3) m_err = 1'b1; else m_pend[r]++;
      end else if (d && !i) begin
        if (m_pend[r] == 0) m_err = 1'b1; else m_pend[r]--;
      end
    end
    if (wb_reg_write && wb_write_reg != 0) m_regs[wb_write_reg] = wb_data;
  endfunction

  // Drive one cycle of inputs, push the expectation, advance past the edge.
  task automatic cyc(input string tag, input bit r, input bit we, input int wr,
                     input logic [31:0] wd, input int rs, input int rt,
                     input bit iv, input int idst, input int dbg);
    exp_t e;
    rst = r; wb_reg_write = we; wb_write_reg = 5'(wr); wb_data = wd;
    id_rs = 5'(rs); id_rt = 5'(rt); iss_valid = iv; iss_dest = 5'(idst);
    dbg_addr = 5'(dbg);
    e.tag = tag;
    if (r) begin
      m_clear();
      e.rs_d = '0; e.rt_d = '0; e.dbg_d = '0; e.stall = 1'b0; e.err = 1'b0;
    end else begin
      e.rs_d  = m_read(rs);
      e.rt_d  = m_read(rt);
      e.dbg_d = m_regs[dbg];
      e.stall = m_hz(rs) || m_hz(rt);
      e.err   = m_err;
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (!r) m_clock();
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".rs_data"}, id_rs_data, e.rs_d);
      chk({e.tag, ".rt_data"}, id_rt_data, e.rt_d);
      chk({e.tag, ".dbg_data"}, dbg_data, e.dbg_d);
      chk({e.tag, ".stall"}, 32'(hazard_stall), 32'(e.stall));
      chk({e.tag, ".sb_err"}, 32'(sb_err), 32'(e.err));
    end
  end

  initial begin
    rst = 1'b1; wb_reg_write = 0; wb_write_reg = 0; wb_data = 0;
    id_rs = 0; id_rt = 0; iss_valid = 0; iss_dest = 0; dbg_addr = 0;
    m_clear();
    @(posedge clk); #1;
    cyc("reset", 1, 0, 0, 0, 5, 6, 0, 0, 7);

    // Mid-run reset clears data, counters and error at once, bypass disabled.
    cyc("t1_w5", 0, 1, 5, 32'h5555_0005, 0, 0, 1, 6, 5);
    cyc("t1_w6", 0, 1, 6, 32'h6666_0006, 5, 0, 1, 6, 5);
    cyc("t1_w7", 0, 1, 7, 32'h7777_0007, 5, 6, 0, 0, 6);
    cyc("t1_rst", 1, 1, 5, 32'hFFFF_FFFF, 5, 6, 0, 0, 7);
    cyc("t1_post", 0, 0, 0, 0, 5, 6, 0, 0, 7);

    // Write then read; r0 write ignored.
    cyc("t2_w5", 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 5);
    cyc("t2_r5", 0, 0, 0, 0, 5, 0, 0, 0, 5);
    cyc("t2_w0", 0, 1, 0, 32'h0000_1234, 0, 0, 0, 0, 0);
    cyc("t2_r0", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle bypass while debug port shows the old array value.
    cyc("t3_w7", 0, 1, 7, 32'h1111_2222, 0, 0, 0, 0, 7);
    cyc("t3_byp", 0, 1, 7, 32'hA5A5_A5A5, 0, 7, 0, 0, 7);
    cyc("t3_after", 0, 0, 0, 0, 0, 7, 0, 0, 7);

    // Single in-flight write: stall, then forwarded on writeback.
    cyc("t4_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t4_iss", 0, 0, 0, 0, 3, 0, 1, 3, 3);
    cyc("t4_stall", 0, 0, 0, 0, 3, 0, 0, 0, 3);
    cyc("t4_wb", 0, 1, 3, 32'h0000_0011, 3, 0, 0, 0, 3);
    cyc("t4_clear", 0, 0, 0, 0, 0, 3, 0, 0, 3);

    // Overflow saturates at 3; underflow on the 4th writeback.
    for (int i = 0; i < 4; i++) cyc("t5_iss", 0, 0, 0, 0, 9, 0, 1, 9, 9);
    cyc("t5_chk", 0, 0, 0, 0, 9, 9, 0, 0, 9);
    for (int i = 0; i < 3; i++) cyc("t5_wb", 0, 1, 9, 32'(i + 32'h90), 9, 0, 0, 0, 9);
    cyc("t5_idle", 0, 0, 0, 0, 9, 0, 0, 0, 9);
    cyc("t5_wb4", 0, 1, 9, 32'h99, 0, 9, 0, 0, 9);
    cyc("t5_end", 0, 0, 0, 0, 9, 0, 0, 0, 9);

    // Issue and writeback to the same register in one cycle cancel out.
    cyc("t6_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("t6_iss", 0, 0, 0, 0, 0, 0, 1, 4, 4);
    cyc("t6_both", 0, 1, 4, 32'h44, 4, 0, 1, 4, 4);
    cyc("t6_next", 0, 0, 0, 0, 4, 0, 0, 0, 4);
    cyc("t6_iss0", 0, 1, 0, 32'h7, 0, 4, 1, 0, 4);

    // Random traffic over a narrow register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      bit rr;
      rr = ($urandom_range(0, 199) == 0);
      cyc("rand", rr, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)));
    end
    rst = 1'b0; wb_reg_write = 0; iss_valid = 0;

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
